// File: rtl/fir_tap_sequencer_if.sv
// Control bundle between the FIR tap sequencer and the FIFO/coefficient/datapath side.
// master = sequencer, slave = FIFO, coefficient loader and MAC datapath.
interface fir_tap_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             fifo_empty;
  logic             PushCoef;
  logic             fifo_pull;
  logic [1:0]       mux_sel;
  logic             acc_clear;
  logic             acc_valid;
  logic             round_en;
  logic             busy;
  logic             coef_conflict;
  logic [CNT_W-1:0] sample_cnt;
  logic [2:0]       state_dbg;

  modport master (
    input  fifo_empty, PushCoef,
    output fifo_pull, mux_sel, acc_clear, acc_valid, round_en,
           busy, coef_conflict, sample_cnt, state_dbg
  );

  modport slave (
    output fifo_empty, PushCoef,
    input  fifo_pull, mux_sel, acc_clear, acc_valid, round_en,
           busy, coef_conflict, sample_cnt, state_dbg
  );
endinterface

// File: rtl/fir_tap_sequencer.sv
// Per-sample sequencer: pulls one FIFO entry, steps the multiplier bank through the
// coefficient groups, and lines accumulate/round strobes up with the multiplier pipeline.
module fir_tap_sequencer #(
  parameter int NUM_GROUPS = 3,
  parameter int MULT_LAT   = 2,
  parameter int CNT_W      = 16
) (
  input logic                 clk,
  input logic                 Reset,
  fir_tap_sequencer_if.master bus
);
  // Handshake: fifo_pull is a one-cycle pop strobe with no ready back; it is only
  // issued after a cycle in which fifo_empty was low and PushCoef was low.
  typedef enum logic [2:0] {IDLE, PULL, MULT, DRAIN, ROUND} state_t;

  localparam logic [1:0] GRP_LAST   = 2'(NUM_GROUPS - 1);
  localparam logic [1:0] DRAIN_LAST = 2'(MULT_LAT - 1);

  state_t              state, state_nxt;
  logic [1:0]          grp, grp_nxt;
  logic [1:0]          dcnt, dcnt_nxt;
  logic [MULT_LAT-1:0] issue_pipe;
  logic                conflict;
  logic [CNT_W-1:0]    cnt;
  logic                start_ok;

  assign start_ok = !bus.fifo_empty && !bus.PushCoef;

  always_comb begin
    state_nxt = state;
    grp_nxt   = grp;
    dcnt_nxt  = dcnt;
    case (state)
      IDLE:  if (start_ok) state_nxt = PULL;
      PULL: begin
        state_nxt = MULT;
        grp_nxt   = 2'd0;
      end
      MULT: begin
        if (grp == GRP_LAST) begin
          state_nxt = DRAIN;
          dcnt_nxt  = 2'd0;
        end else begin
          grp_nxt = grp + 2'd1;
        end
      end
      DRAIN: begin
        if (dcnt == DRAIN_LAST) state_nxt = ROUND;
        else                    dcnt_nxt  = dcnt + 2'd1;
      end
      ROUND: state_nxt = start_ok ? PULL : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // grp only reloads on entry to MULT, so mux_sel holds the last issued group otherwise.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      grp        <= 2'd0;
      dcnt       <= 2'd0;
      issue_pipe <= '0;
      conflict   <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      grp        <= grp_nxt;
      dcnt       <= dcnt_nxt;
      issue_pipe <= (issue_pipe << 1) | MULT_LAT'(state == MULT);
      if (bus.PushCoef && (state == PULL || state == MULT || state == DRAIN))
        conflict <= 1'b1;
      if (state == ROUND && cnt != '1)
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.fifo_pull     = (state == PULL);
  assign bus.mux_sel       = grp;
  assign bus.acc_clear     = (state == MULT) && (grp == 2'd0);
  assign bus.acc_valid     = issue_pipe[MULT_LAT-1];
  assign bus.round_en      = (state == ROUND);
  assign bus.busy          = (state != IDLE);
  assign bus.coef_conflict = conflict;
  assign bus.sample_cnt    = cnt;
  assign bus.state_dbg     = state;
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: default instance plus a NUM_GROUPS=4 / MULT_LAT=1 / CNT_W=2
// instance, both tracked every cycle by a schedule-based reference model.
module tb_fir_tap_sequencer;
  logic clk = 1'b0;
  logic Reset;
  logic fe, pc;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_tap_sequencer_if #(.CNT_W(16)) if0 ();
  fir_tap_sequencer_if #(.CNT_W(2))  if1 ();
  assign if0.fifo_empty = fe;
  assign if0.PushCoef   = pc;
  assign if1.fifo_empty = fe;
  assign if1.PushCoef   = pc;

  fir_tap_sequencer #(.NUM_GROUPS(3), .MULT_LAT(2), .CNT_W(16)) dut0 (
    .clk(clk), .Reset(Reset), .bus(if0.master));
  fir_tap_sequencer #(.NUM_GROUPS(4), .MULT_LAT(1), .CNT_W(2)) dut1 (
    .clk(clk), .Reset(Reset), .bus(if1.master));

  // Reference model: each sample is described only by its pull cycle T.
  int ng   [2] = '{3, 4};
  int ml   [2] = '{2, 1};
  int cmax [2] = '{65535, 3};
  int t_pull [2] = '{-1, -1};
  int last_mux [2] = '{0, 0};
  int m_cnt [2] = '{0, 0};
  int m_conf [2] = '{0, 0};
  int n_pull [2] = '{0, 0};
  int n_val [2] = '{0, 0};
  int n_rnd [2] = '{0, 0};
  int n_busy [2] = '{0, 0};

  typedef struct {
    int pull, mux, clr, val, rnd, busy, conf, cnt;
  } obs_t;

  function automatic obs_t observe(input int k);
    obs_t o;
    if (k == 0) begin
      o.pull = int'(if0.fifo_pull); o.mux = int'(if0.mux_sel); o.clr = int'(if0.acc_clear);
      o.val = int'(if0.acc_valid); o.rnd = int'(if0.round_en); o.busy = int'(if0.busy);
      o.conf = int'(if0.coef_conflict); o.cnt = int'(if0.sample_cnt);
    end else begin
      o.pull = int'(if1.fifo_pull); o.mux = int'(if1.mux_sel); o.clr = int'(if1.acc_clear);
      o.val = int'(if1.acc_valid); o.rnd = int'(if1.round_en); o.busy = int'(if1.busy);
      o.conf = int'(if1.coef_conflict); o.cnt = int'(if1.sample_cnt);
    end
    return o;
  endfunction

  task automatic chk(input string name, input int k, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s inst%0d cyc=%0d actual=%0d expected=%0d", name, k, cyc, act, exp);
  endtask

  task automatic check_obs(input string tag, input int k, input obs_t a, input obs_t e);
    chk({tag, ".fifo_pull"}, k, a.pull, e.pull);
    chk({tag, ".mux_sel"}, k, a.mux, e.mux);
    chk({tag, ".acc_clear"}, k, a.clr, e.clr);
    chk({tag, ".acc_valid"}, k, a.val, e.val);
    chk({tag, ".round_en"}, k, a.rnd, e.rnd);
    chk({tag, ".busy"}, k, a.busy, e.busy);
    chk({tag, ".coef_conflict"}, k, a.conf, e.conf);
    chk({tag, ".sample_cnt"}, k, a.cnt, e.cnt);
  endtask

  task automatic model_step(input int k);
    obs_t a, e;
    int c, t, p, g, v;
    bit active;
    c = cyc;
    a = observe(k);
    n_pull[k] += a.pull; n_val[k] += a.val; n_rnd[k] += a.rnd; n_busy[k] += a.busy;
    if (Reset) begin
      e = '{0, 0, 0, 0, 0, 0, 0, 0};
      t_pull[k] = -1; last_mux[k] = 0; m_cnt[k] = 0; m_conf[k] = 0;
      check_obs("model_rst", k, a, e);
      return;
    end
    t = t_pull[k];
    p = ng[k] + ml[k] + 2;
    active = (t >= 0) && (c >= t) && (c <= t + p - 1);
    g = c - t - 1;
    v = c - t - 1 - ml[k];
    e.pull = int'(active && c == t);
    e.mux  = (active && g >= 0 && g < ng[k]) ? g : last_mux[k];
    e.clr  = int'(active && g == 0);
    e.val  = int'(active && v >= 0 && v < ng[k]);
    e.rnd  = int'(active && c == t + p - 1);
    e.busy = int'(active);
    e.conf = m_conf[k];
    e.cnt  = m_cnt[k];
    check_obs("model", k, a, e);
    last_mux[k] = e.mux;
    if (e.rnd != 0 && m_cnt[k] < cmax[k]) m_cnt[k]++;
    if (pc && active && c <= t + ng[k] + ml[k]) m_conf[k] = 1;
    if (!active || e.rnd != 0) t_pull[k] = (!fe && !pc) ? c + 1 : -1;
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    Reset = 1'b1; fe = 1'b1; pc = 1'b0;
    step();
    step();
    Reset = 1'b0;
  endtask

  typedef struct {
    bit fe, pc;
    int pull, mux, clr, val, rnd, busy, cnt;
  } vec_t;
  vec_t vec [10];

  initial begin
    obs_t a;
    int s_pull, s_val0, s_val1, s_rnd, s_busy0, s_busy1;

    vec[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    vec[1] = '{1, 0, 1, 0, 0, 0, 0, 1, 0};
    vec[2] = '{1, 0, 0, 0, 1, 0, 0, 1, 0};
    vec[3] = '{1, 0, 0, 1, 0, 0, 0, 1, 0};
    vec[4] = '{1, 0, 0, 2, 0, 1, 0, 1, 0};
    vec[5] = '{1, 0, 0, 2, 0, 1, 0, 1, 0};
    vec[6] = '{1, 0, 0, 2, 0, 1, 0, 1, 0};
    vec[7] = '{1, 0, 0, 2, 0, 0, 1, 1, 0};
    vec[8] = '{1, 0, 0, 2, 0, 0, 0, 0, 1};
    vec[9] = '{1, 0, 0, 2, 0, 0, 0, 0, 1};

    Reset = 1'b1; fe = 1'b1; pc = 1'b0;
    step();
    for (int k = 0; k < 2; k++) check_obs("reset_vals", k, observe(k), '{0, 0, 0, 0, 0, 0, 0, 0});
    step();
    Reset = 1'b0;

    // Single sample at defaults, table driven.
    for (int i = 0; i < 10; i++) begin
      step();
      fe = vec[i].fe; pc = vec[i].pc;
      @(negedge clk);
      a = observe(0);
      chk("tbl.fifo_pull", i, a.pull, vec[i].pull);
      chk("tbl.mux_sel", i, a.mux, vec[i].mux);
      chk("tbl.acc_clear", i, a.clr, vec[i].clr);
      chk("tbl.acc_valid", i, a.val, vec[i].val);
      chk("tbl.round_en", i, a.rnd, vec[i].rnd);
      chk("tbl.busy", i, a.busy, vec[i].busy);
      chk("tbl.sample_cnt", i, a.cnt, vec[i].cnt);
    end

    // Continuous FIFO data: exactly four samples back to back.
    do_reset();
    s_pull = n_pull[0]; s_val0 = n_val[0]; s_val1 = n_val[1]; s_rnd = n_rnd[0];
    s_busy0 = n_busy[0]; s_busy1 = n_busy[1];
    for (int i = 0; i < 32; i++) begin
      step();
      fe = (i < 22) ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    #1;
    chk("cont.pulls", 0, n_pull[0] - s_pull, 4);
    chk("cont.acc_valid", 0, n_val[0] - s_val0, 12);
    chk("cont.acc_valid", 1, n_val[1] - s_val1, 16);
    chk("cont.round_en", 0, n_rnd[0] - s_rnd, 4);
    chk("cont.busy_cycles", 0, n_busy[0] - s_busy0, 28);
    chk("cont.busy_cycles", 1, n_busy[1] - s_busy1, 28);
    chk("cont.sample_cnt", 0, int'(if0.sample_cnt), 4);
    chk("cont.sample_cnt_sat", 1, int'(if1.sample_cnt), 3);

    // PushCoef held while idle with data waiting.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step();
      fe = (i <= 5) ? 1'b0 : 1'b1;
      pc = (i < 5) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (i == 5) chk("hold.no_pull", 0, int'(if0.fifo_pull), 0);
      if (i == 6) chk("hold.pull", 0, int'(if0.fifo_pull), 1);
    end
    chk("hold.conflict", 0, int'(if0.coef_conflict), 0);
    chk("hold.sample_cnt", 0, int'(if0.sample_cnt), 1);

    // PushCoef pulse during MULT.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step();
      fe = (i == 0) ? 1'b0 : 1'b1;
      pc = (i == 3) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (i == 4) chk("mid.conflict_set", 0, int'(if0.coef_conflict), 1);
      if (i == 7) chk("mid.round_en", 0, int'(if0.round_en), 1);
    end
    chk("mid.conflict_sticky", 0, int'(if0.coef_conflict), 1);
    chk("mid.sample_cnt", 0, int'(if0.sample_cnt), 1);
    do_reset();
    chk("mid.conflict_cleared", 0, int'(if0.coef_conflict), 0);

    // Asynchronous reset in the second MULT cycle.
    for (int i = 0; i < 4; i++) begin
      step();
      fe = (i == 0) ? 1'b0 : 1'b1;
    end
    #2;
    Reset = 1'b1;
    #1;
    check_obs("async_rst", 0, observe(0), '{0, 0, 0, 0, 0, 0, 0, 0});
    s_val0 = n_val[0]; s_rnd = n_rnd[0];
    step();
    step();
    Reset = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("async.no_acc_valid", 0, n_val[0] - s_val0, 0);
    chk("async.no_round_en", 0, n_rnd[0] - s_rnd, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      fe = (i == 0) ? 1'b0 : 1'b1;
    end
    chk("async.next_vals", 0, n_val[0] - s_val0, 3);
    chk("async.next_round", 0, n_rnd[0] - s_rnd, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      step();
      fe    = ($urandom_range(0, 3) == 0);
      pc    = ($urandom_range(0, 9) == 0);
      Reset = ($urandom_range(0, 249) == 0);
    end
    step();
    Reset = 1'b0;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Sequencing controller for the complex FIR datapath. For each input sample it pulls one entry from the sample FIFO and steps the shared multiplier bank through the coefficient groups. It tracks multiplier pipeline latency, so partial-product accumulation and final rounding strobes line up with results leaving the pipelined multipliers. It also keeps sample pulls away from coefficient writes and flags any write that lands mid-computation.

## Interface
Parameters:
- NUM_GROUPS, 3, coefficient groups per sample (15 folded taps / 5 multipliers); legal 1..4
- MULT_LAT, 2, multiplier pipeline depth in cycles (two-stage multiplier); legal 1..4
- CNT_W, 16, width of processed-sample counter

Ports:
- clk  in  1  clock, all state changes on rising edge
- Reset  in  1  asynchronous, active-high reset
- fifo_empty  in  1  sample FIFO has no entry
- PushCoef  in  1  coefficient write in progress this cycle
- fifo_pull  out  1  one-cycle pull strobe to FIFO and sample shift register
- mux_sel  out  2  coefficient/sample group issued to the multiplier bank
- acc_clear  out  1  clear partial-product accumulators (first group issue of a sample)
- acc_valid  out  1  multiplier output valid, accumulate this cycle
- round_en  out  1  final accumulate and round; datapath raises PushOut from this
- busy  out  1  state is not IDLE
- coef_conflict  out  1  sticky: PushCoef seen while a sample was in computation
- sample_cnt  out  CNT_W  samples fully processed (round_en pulses), saturating

## Operation
- States: IDLE, PULL, MULT, DRAIN, ROUND.
- IDLE -> PULL when fifo_empty=0 and PushCoef=0; otherwise stay.
- PULL: fifo_pull=1 for exactly one cycle. Go to MULT.
- MULT: lasts NUM_GROUPS cycles. grp counter 0..NUM_GROUPS-1 drives mux_sel. acc_clear=1 only while grp=0. Go to DRAIN after the last group.
- DRAIN: lasts MULT_LAT cycles. No new issue. Go to ROUND.
- ROUND: round_en=1 for one cycle; sample_cnt increments, holding at all-ones.
  - From ROUND, go to PULL if fifo_empty=0 and PushCoef=0.
  - Otherwise go to IDLE.
- Issue pipeline: a MULT_LAT-deep shift register is loaded with 1 each MULT cycle and 0 otherwise. Its output is acc_valid. Exactly NUM_GROUPS acc_valid pulses per sample, all before round_en.
- Coefficient hold-off: PushCoef blocks the IDLE->PULL and ROUND->PULL transitions only. It never stalls a sample already pulled.
- coef_conflict sets when PushCoef=1 in PULL, MULT, or DRAIN. It stays set until Reset.
- mux_sel holds its last issued value outside MULT, and is 0 after reset.
- fifo_empty is sampled only in IDLE and ROUND. A FIFO going empty mid-sample has no effect.

## Timing
- Reset values: every output 0, state IDLE, grp=0, issue pipeline cleared.
- Reset asserted mid-sample aborts immediately. No acc_valid or round_en appears after Reset, including pulses already in flight in the issue pipeline.
- Outputs are registered; no combinational path from inputs to outputs.
- Let fifo_pull be high in cycle T:
  - mux_sel=g at T+1+g
  - acc_clear at T+1
  - acc_valid at T+1+g+MULT_LAT
  - round_en at T+1+NUM_GROUPS+MULT_LAT
- Defaults: pull T, mux_sel 0/1/2 at T+1..T+3, acc_valid T+3..T+5, round_en T+6.
- Back-to-back throughput: one sample per NUM_GROUPS+MULT_LAT+2 cycles (7 at defaults). The next fifo_pull comes at T+7.
- From IDLE, first fifo_pull is one cycle after fifo_empty falls (with PushCoef low).
- busy is high from PULL through ROUND inclusive.

## Test plan
- Single sample, defaults: fifo_empty falls at cycle 0. Expect:
  - fifo_pull at 1
  - mux_sel 0,1,2 at 2,3,4 and acc_clear at 2
  - acc_valid at 4,5,6
  - round_en at 7, then sample_cnt=1 and busy=0 at 8
- Continuous FIFO data, 4 samples: fifo_pull every 7 cycles, 12 acc_valid pulses, 4 round_en pulses, sample_cnt=4, no gaps in busy.
- PushCoef held high 5 cycles while IDLE with FIFO non-empty: no fifo_pull until the cycle after PushCoef drops; coef_conflict stays 0.
- PushCoef one cycle during MULT: sample completes with normal timing; coef_conflict=1 and stays 1 until Reset.
- Reset asserted in the second MULT cycle: all outputs 0 asynchronously, no acc_valid or round_en after release; next sample runs with full normal timing.
- MULT_LAT=1, NUM_GROUPS=4: mux_sel 0..3 at T+1..T+4, acc_valid T+2..T+5, round_en T+6, 7-cycle period.
